// File: rtl/dsm_decim.sv
// rtl/dsm_decim.sv - sinc^ORDER CIC decimator recovering the 16.16 target from a MASH output stream.
// Optional macro DSM_DECIM_SETTLE_EN hides the first ORDER-1 unsettled results after reset.
module dsm_decim #(
  parameter int ORDER = 5,
  parameter int LOG2R = 8,
  localparam int ACCW = 16 + ORDER * LOG2R
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_value,
  input  logic        in_valid,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ovf,
  input  logic        clr_ovf
);

  localparam int SH = ORDER * LOG2R - 16;

  logic [ACCW-1:0]  integ_q [ORDER];
  logic [ACCW-1:0]  integ_d [ORDER];
  logic [LOG2R-1:0] cnt_q;
  logic [LOG2R-1:0] cnt_d;
  logic             strobe;

  logic [ACCW-1:0]  comb_q [ORDER+1];
  logic [ACCW-1:0]  dly_q  [ORDER];
  logic [ORDER:0]   vld_q;

  logic [31:0]      res_data;
  logic             res_vld;

  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  // Integrators chain on next-state values so the strobe sample reaches I_ORDER at once.
  always_comb begin
    integ_d = integ_q;
    cnt_d   = cnt_q;
    if (in_valid) begin
      integ_d[0] = integ_q[0] + {{(ACCW-16){1'b0}}, in_value};
      for (int k = 1; k < ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_d[k-1];
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign strobe = in_valid && (cnt_q == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      integ_q <= integ_d;
      cnt_q   <= cnt_d;
    end
  end

  // Comb stage k consumes comb_q[k-1]; dly_q[k-1] holds its previous decimated input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= ORDER; k++) begin
        comb_q[k] <= '0;
      end
      for (int k = 0; k < ORDER; k++) begin
        dly_q[k] <= '0;
      end
      vld_q <= '0;
    end else begin
      vld_q[0] <= strobe;
      if (strobe) begin
        comb_q[0] <= integ_d[ORDER-1];
      end
      for (int k = 1; k <= ORDER; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          comb_q[k]  <= comb_q[k-1] - dly_q[k-1];
          dly_q[k-1] <= comb_q[k-1];
        end
      end
    end
  end

  assign res_data = 32'(comb_q[ORDER] >> SH);

`ifdef DSM_DECIM_SETTLE_EN
  localparam logic [2:0] SETTLE_N = 3'(ORDER - 1);

  logic [2:0] settle_q;
  logic       settled;

  assign settled = (settle_q == SETTLE_N);
  assign res_vld = vld_q[ORDER] && settled;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
    end else if (vld_q[ORDER] && !settled) begin
      settle_q <= settle_q + 1'b1;
    end
  end
`else
  assign res_vld = vld_q[ORDER];
`endif

  // A drop sets ovf after the clear is applied, so a simultaneous set wins.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (res_vld) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = res_data;
        out_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsm_decim.sv
// tb/tb_dsm_decim.sv - scoreboard bench for dsm_decim (honours DSM_DECIM_SETTLE_EN).
module tb_dsm_decim;

  localparam int ORDER = 5;
  localparam int LOG2R = 8;
  localparam int R     = 1 << LOG2R;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_value = '0;
  logic        in_valid = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        ovf;
  logic        clr_ovf = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk;
  } sb_t;

  sb_t         sb [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          samp_cnt = 0;
  int          win = 0;
  bit          mon_en = 1'b0;
  bit          push_en = 1'b0;
  logic [31:0] cur_exp = '0;
  string       cur_test = "none";
  int          last_out_cyc = 0;
  int          prev_out_cyc = 0;

  dsm_decim #(.ORDER(ORDER), .LOG2R(LOG2R)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_value  (in_value),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && !rst && out_valid && out_ready) begin
      prev_out_cyc = last_out_cyc;
      last_out_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected output: got data=%h, expected no output", cur_test, out_data);
      end else begin
        automatic sb_t e = sb.pop_front();
        if (cyc !== e.cyc + ORDER + 1) begin
          errors++;
          $display("FAIL %s latency: got cycle %0d, expected %0d", cur_test, cyc, e.cyc + ORDER + 1);
        end
        checks++;
        if (e.chk) begin
          if (out_data !== e.data) begin
            errors++;
            $display("FAIL %s data: got %h, expected %h", cur_test, out_data, e.data);
          end
        end else if (!(out_data < e.data)) begin
          errors++;
          $display("FAIL %s transient: got %h, expected below %h", cur_test, out_data, e.data);
        end
      end
    end
  end

  task automatic step(input logic [15:0] v, input logic val);
    in_value = v;
    in_valid = val;
    @(posedge clk);
    #1;
    if (val) begin
      samp_cnt++;
      if (samp_cnt % R == 0) begin
        win++;
        if (push_en) begin
`ifdef DSM_DECIM_SETTLE_EN
          if (win >= ORDER) sb.push_back('{cur_exp, cyc, 1'b1});
`else
          sb.push_back('{cur_exp, cyc, (win >= ORDER)});
`endif
        end
      end
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    sb.delete();
    samp_cnt = 0;
    win      = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step(16'h0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d results outstanding, expected 0", cur_test, sb.size());
    end
  endtask

  task automatic start(input string name, input logic [31:0] exp);
    cur_test = name;
    do_reset();
    cur_exp   = exp;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    push_en   = 1'b1;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    do_reset();
    checks += 3;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset out_data: got %h, expected 0", out_data); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, expected 0", out_valid); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b, expected 0", ovf); end
  endtask

  task automatic test_constant();
    start("constant", 32'h1234_0000);
    repeat (8 * R) step(16'h1234, 1'b1);
    drain();
  endtask

  task automatic test_alternating();
    start("alt2", 32'h0010_8000);
    for (int i = 0; i < 8 * R; i++) step((i % 2) ? 16'h0011 : 16'h0010, 1'b1);
    drain();
    start("alt4", 32'h0010_4000);
    for (int i = 0; i < 8 * R; i++) step((i % 4 == 3) ? 16'h0011 : 16'h0010, 1'b1);
    drain();
  endtask

  task automatic test_gaps();
    start("gaps", 32'h1234_0000);
    repeat (8 * R) begin
      step(16'h1234, 1'b1);
      step(16'h1234, 1'b0);
      step(16'h1234, 1'b0);
    end
    drain();
    checks++;
    if (last_out_cyc - prev_out_cyc !== 3 * R) begin
      errors++;
      $display("FAIL gaps spacing: got %0d clocks, expected %0d", last_out_cyc - prev_out_cyc, 3 * R);
    end
  endtask

  task automatic test_wrap();
    start("wrap", 32'hFFFF_0000);
    repeat (20 * R) step(16'hFFFF, 1'b1);
    drain();
  endtask

  task automatic test_ovf();
    start("ovf", 32'h1234_0000);
    repeat (ORDER * R) step(16'h1234, 1'b1);
    drain();
    out_ready = 1'b0;
    mon_en    = 1'b0;
    push_en   = 1'b0;
    repeat (R) step(16'h1234, 1'b1);
    repeat (ORDER + 2) step(16'h0, 1'b0);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf first valid: got %b, expected 1", out_valid); end
    if (out_data !== 32'h1234_0000) begin errors++; $display("FAIL ovf first data: got %h, expected 12340000", out_data); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf after first: got %b, expected 0", ovf); end
    repeat (R) step(16'h2000, 1'b1);
    repeat (ORDER + 2) step(16'h0, 1'b0);
    checks += 3;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf after second: got %b, expected 1", ovf); end
    if (out_data !== 32'h1234_0000) begin errors++; $display("FAIL ovf held data: got %h, expected 12340000", out_data); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf held valid: got %b, expected 1", out_valid); end
    clr_ovf = 1'b1;
    step(16'h0, 1'b0);
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf clear: got %b, expected 0", ovf); end
    repeat (R) step(16'h2000, 1'b1);
    repeat (ORDER) step(16'h0, 1'b0);
    clr_ovf = 1'b1;
    step(16'h0, 1'b0);
    clr_ovf = 1'b0;
    checks += 2;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf set wins: got %b, expected 1", ovf); end
    if (out_data !== 32'h1234_0000) begin errors++; $display("FAIL ovf third data: got %h, expected 12340000", out_data); end
    out_ready = 1'b1;
    step(16'h0, 1'b0);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf consume valid: got %b, expected 0", out_valid); end
    if (out_data !== 32'h1234_0000) begin errors++; $display("FAIL ovf consume data: got %h, expected 12340000", out_data); end
  endtask

  task automatic test_mid_reset();
    cur_test = "midreset";
    mon_en   = 1'b0;
    push_en  = 1'b0;
    repeat (100) step(16'h1234, 1'b1);
    #3 rst = 1'b1;
    #1;
    checks += 3;
    if (out_data !== 32'h0) begin errors++; $display("FAIL midreset out_data: got %h, expected 0", out_data); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b, expected 0", out_valid); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL midreset ovf: got %b, expected 0", ovf); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    samp_cnt  = 0;
    win       = 0;
    cur_exp   = 32'h0100_0000;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    push_en   = 1'b1;
    repeat (6 * R) step(16'h0100, 1'b1);
    drain();
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete within 2 ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_constant();
    test_alternating();
    test_gaps();
    test_wrap();
    test_ovf();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
